// File: rtl/rom_loader.sv
// rom_loader: ioctl download port to SDRAM boot-write bridge.
// Decodes the image index and file extension into an SDRAM page, mirrors
// writes across banks, paces the host with ioctl_wait and records which
// expansion pages have been written.
// Optional build macro: COMBO_LOAD_EN (extension "Z0" loads a combo image
// whose first 16 KB land in page 0x000 and the remainder in the MF2 slot).
module rom_loader #(
  parameter int PAGE_W = 8,
  parameter int NUM_BANKS = 2,
  parameter logic [PAGE_W-1:0] MALFORMED_PAGE = PAGE_W'(8'hEE),
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ADDR_W = PAGE_W + 15,
  localparam int MAP_W = 2 ** PAGE_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_ref,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [15:0]       ioctl_file_ext,
  output logic              ioctl_wait,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_bank,
  output logic [7:0]        mem_din,
  output logic [MAP_W-1:0]  rom_map,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WRITE} state_t;

  localparam logic [7:0]        MF_BYTE   = 8'(MALFORMED_PAGE);
  localparam logic [15:0]       EXT_ZZ    = 16'h5A5A;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  // One ASCII hex digit to a nibble, falling back to dflt for non-hex text.
  function automatic logic [3:0] hex_nib(input logic [7:0] ch, input logic [3:0] dflt);
    if (ch >= 8'h30 && ch <= 8'h39)      hex_nib = ch[3:0];
    else if (ch >= 8'h41 && ch <= 8'h46) hex_nib = ch[3:0] + 4'd9;
    else                                 hex_nib = dflt;
  endfunction

  // Extension text to {exp_flag, page}; "ZZ" selects the non-expansion page 0.
  function automatic logic [PAGE_W:0] ext_page(input logic [15:0] ext);
    logic [7:0] p;
    p = {hex_nib(ext[15:8], MF_BYTE[7:4]), hex_nib(ext[7:0], MF_BYTE[3:0])};
    if (ext == EXT_ZZ) ext_page = '0;
    else               ext_page = {1'b1, PAGE_W'(p)};
  endfunction

  // System ROM set slots: base, expansion 0, expansion 7, MF2 (all ones).
  function automatic logic [PAGE_W:0] slot_page(input logic [1:0] slot);
    case (slot)
      2'd0:    slot_page = '0;
      2'd1:    slot_page = {1'b1, PAGE_W'(0)};
      2'd2:    slot_page = {1'b1, PAGE_W'(7)};
      default: slot_page = '1;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic                dl_q;
  logic [PAGE_W:0]     page_q, page_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [7:0]          din_q, din_d;
  logic                mirror_q, mirror_d;
  logic                wr_q, wr_d;
  logic                wait_q, wait_d;
  logic [MAP_W-1:0]    map_q, map_d;

  logic                start, accept, no_add, mir_sel;
  logic [PAGE_W:0]     page_dec, page_cur, sel;
  logic [PAGE_W-1:0]   page_off;
  logic [BANK_W-1:0]   bank_sel;
  logic [10:0]         seg;

`ifdef COMBO_LOAD_EN
  localparam logic [15:0] EXT_Z0 = 16'h5A30;
  logic combo_q, combo_d, combo_img_q, combo_img_d, combo_dec;
`endif

  // Next-state: page decode on download start, byte acceptance and the write FSM.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    din_d    = din_q;
    mirror_d = mirror_q;
    wr_d     = wr_q;
    wait_d   = wait_q;
    map_d    = map_q;
    start    = ioctl_download & ~dl_q & (ioctl_index != 8'd0);
    page_dec = ext_page(ioctl_file_ext);
`ifdef COMBO_LOAD_EN
    combo_d     = combo_q;
    combo_img_d = combo_img_q;
    combo_dec   = (ioctl_file_ext == EXT_Z0);
    if (combo_dec) page_dec = '0;
    no_add      = start ? combo_dec : combo_img_q;
`else
    no_add      = 1'b0;
`endif
    // A start in the same cycle as a byte applies to that byte.
    page_cur = start ? page_dec : page_q;
    seg      = ioctl_addr[24:14];
    page_off = no_add ? '0 : PAGE_W'(ioctl_addr[21:14]);
    accept   = 1'b0;
    sel      = '0;
    bank_sel = '0;
    mir_sel  = 1'b0;
    if (ioctl_index != 8'd0) begin
      accept  = 1'b1;
      sel     = {page_cur[PAGE_W], page_cur[PAGE_W-1:0] + page_off};
      mir_sel = (ioctl_index[7:6] == 2'd1) | (|ioctl_index[5:0]);
      if (!mir_sel && ioctl_index[7:6] == 2'd3) bank_sel = BANK_W'(1);
    end else if (seg < 11'(4 * NUM_BANKS)) begin
      accept   = 1'b1;
      sel      = slot_page(seg[1:0]);
      bank_sel = BANK_W'(seg[10:2]);
    end

    case (state_q)
      S_IDLE: begin
        if (ioctl_download && ioctl_wr && accept) begin
          addr_d   = {sel, ioctl_addr[13:0]};
          bank_d   = bank_sel;
          din_d    = ioctl_dout;
          mirror_d = mir_sel;
          wait_d   = 1'b1;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        if (ce_ref) begin
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      default: begin
        if (ce_ref) begin
          if (mirror_q && (bank_q < LAST_BANK)) begin
            bank_d = bank_q + 1'b1;
          end else begin
            wr_d    = 1'b0;
            wait_d  = 1'b0;
            state_d = S_IDLE;
            if (addr_q[ADDR_W-1]) map_d[addr_q[ADDR_W-2:14]] = 1'b1;
`ifdef COMBO_LOAD_EN
            if (combo_q && addr_q[13:0] == 14'h3FFF) begin
              combo_d = 1'b0;
              page_d  = '1;
            end
`endif
          end
        end
      end
    endcase

    // Decode never disturbs the latched in-flight write.
    if (start) begin
      page_d = page_dec;
`ifdef COMBO_LOAD_EN
      combo_d     = combo_dec;
      combo_img_d = combo_dec;
`endif
    end
  end

  // State and output registers; reset abandons any write in flight.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      dl_q     <= 1'b0;
      page_q   <= {1'b1, MALFORMED_PAGE};
      addr_q   <= '0;
      bank_q   <= '0;
      din_q    <= '0;
      mirror_q <= 1'b0;
      wr_q     <= 1'b0;
      wait_q   <= 1'b0;
      map_q    <= '0;
`ifdef COMBO_LOAD_EN
      combo_q     <= 1'b0;
      combo_img_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dl_q     <= ioctl_download;
      page_q   <= page_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      din_q    <= din_d;
      mirror_q <= mirror_d;
      wr_q     <= wr_d;
      wait_q   <= wait_d;
      map_q    <= map_d;
`ifdef COMBO_LOAD_EN
      combo_q     <= combo_d;
      combo_img_q <= combo_img_d;
`endif
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_bank   = bank_q;
  assign mem_din    = din_q;
  assign rom_map    = map_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader (PAGE_W=8, NUM_BANKS=2).
module tb_rom_loader;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic         ce_ref;
  logic         ioctl_download;
  logic         ioctl_wr;
  logic [7:0]   ioctl_index;
  logic [24:0]  ioctl_addr;
  logic [7:0]   ioctl_dout;
  logic [15:0]  ioctl_file_ext;
  logic         ioctl_wait;
  logic         mem_wr;
  logic [22:0]  mem_addr;
  logic [0:0]   mem_bank;
  logic [7:0]   mem_din;
  logic [255:0] rom_map;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [255:0] exp_map;

  rom_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_ref(ce_ref),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_file_ext(ioctl_file_ext),
    .ioctl_wait(ioctl_wait), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_bank(mem_bank), .mem_din(mem_din), .rom_map(rom_map), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set beforehand are seen at the posedge.
  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic ce();
    ce_ref = 1'b1;
    step();
    ce_ref = 1'b0;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
    ioctl_download = 1'b0;
    step();
    ioctl_index    = idx;
    ioctl_file_ext = ext;
    ioctl_download = 1'b1;
    step();
  endtask

  // Single-bank write: accept, check latched fields, two ce_ref strobes.
  task automatic one_write(input string tag, input logic [24:0] a, input logic [7:0] d,
                           input logic [22:0] ea, input logic eb);
    send_byte(a, d);
    chk({tag, "_wait"}, ioctl_wait, 1'b1);
    chk({tag, "_addr"}, mem_addr, ea);
    chk({tag, "_bank"}, mem_bank, eb);
    chk({tag, "_din"}, mem_din, d);
    ce();
    chk({tag, "_wr"}, mem_wr, 1'b1);
    ce();
    chk({tag, "_done"}, {ioctl_wait, mem_wr, busy}, 3'b000);
  endtask

  initial begin
    reset_n = 1'b0; ce_ref = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0; ioctl_file_ext = '0;
    exp_map = '0;
    step(); step();
    chk("rst_outs", {ioctl_wait, mem_wr, busy, mem_bank, mem_din, mem_addr}, '0);
    chk("rst_map", rom_map, '0);
    reset_n = 1'b1;
    step();

    // index 1 "07": mirrored write at page 7+1
    start_dl(8'h01, 16'h3037);
    send_byte(25'h0004001, 8'h5A);
    chk("m_wait", ioctl_wait, 1'b1);
    chk("m_busy", busy, 1'b1);
    chk("m_addr", mem_addr, 23'h420001);
    chk("m_bank0", mem_bank, 1'b0);
    chk("m_din", mem_din, 8'h5A);
    send_byte(25'h0000000, 8'hA5);
    chk("m_ignore_din", mem_din, 8'h5A);
    chk("m_arm_wr", mem_wr, 1'b0);
    ce();
    chk("m_wr0", {mem_wr, mem_bank}, 2'b10);
    step();
    chk("m_hold", {mem_wr, ioctl_wait, mem_bank}, 3'b110);
    ce();
    chk("m_wr1", {mem_wr, mem_bank, ioctl_wait}, 3'b111);
    chk("m_addr_hold", mem_addr, 23'h420001);
    chk("m_map_pending", rom_map, '0);
    ce();
    exp_map[8] = 1'b1;
    chk("m_done", {ioctl_wait, mem_wr, busy}, 3'b000);
    chk("m_map", rom_map, exp_map);

    // index 0xC0 "FF": bank 1 only, download dropped mid-write
    start_dl(8'hC0, 16'h4646);
    send_byte(25'h0000000, 8'h33);
    ioctl_download = 1'b0;
    chk("c0_addr", mem_addr, 23'h7FC000);
    chk("c0_bank", mem_bank, 1'b1);
    ce(); ce();
    exp_map[255] = 1'b1;
    chk("c0_done", {ioctl_wait, mem_wr, busy}, 3'b000);
    chk("c0_map", rom_map, exp_map);

    // "Q3" -> malformed hi nibble
    start_dl(8'h80, 16'h5133);
    one_write("q3", 25'h0000000, 8'h44, 23'h78C000, 1'b0);
    exp_map[8'hE3] = 1'b1;
    chk("q3_map", rom_map, exp_map);

    // "ZZ" -> non-expansion page 0, map untouched
    start_dl(8'h80, 16'h5A5A);
    one_write("zz", 25'h0000005, 8'h11, 23'h000005, 1'b0);
    chk("zz_map", rom_map, exp_map);

`ifdef COMBO_LOAD_EN
    start_dl(8'h80, 16'h5A30);
    one_write("z0_a", 25'h0000000, 8'h01, 23'h000000, 1'b0);
    one_write("z0_b", 25'h0003FFF, 8'h02, 23'h003FFF, 1'b0);
    one_write("z0_c", 25'h0004000, 8'h03, 23'h7FC000, 1'b0);
`else
    start_dl(8'h80, 16'h5A30);
    one_write("z0", 25'h0000000, 8'h01, 23'h780000, 1'b0);
`endif

    // index 0: system ROM set slots
    start_dl(8'h00, 16'h0000);
    one_write("s0", 25'h0000000, 8'h10, 23'h000000, 1'b0);
    one_write("s1", 25'h0004000, 8'h20, 23'h400000, 1'b0);
    one_write("s2", 25'h0008000, 8'h30, 23'h41C000, 1'b0);
    one_write("s3", 25'h000C000, 8'h40, 23'h7FC000, 1'b0);
    one_write("s4", 25'h0010000, 8'h50, 23'h000000, 1'b1);
    send_byte(25'h0020000, 8'h60);
    chk("s8_drop", {ioctl_wait, busy, mem_wr}, 3'b000);
    step();
    chk("s8_drop2", {ioctl_wait, busy}, 2'b00);

    // asynchronous reset while writing
    start_dl(8'h01, 16'h3037);
    send_byte(25'h0004001, 8'h5A);
    ce();
    chk("r_pre", mem_wr, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("r_async", {mem_wr, ioctl_wait, busy}, 3'b000);
    chk("r_map", rom_map, '0);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    send_byte(25'h0000002, 8'h77);
    chk("r_addr", mem_addr, 23'h41C002);
    chk("r_wait", ioctl_wait, 1'b1);
    ce(); ce(); ce();
    exp_map = '0;
    exp_map[7] = 1'b1;
    chk("r_done", {ioctl_wait, mem_wr, busy}, 3'b000);
    chk("r_map2", rom_map, exp_map);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
